// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC constants and types used by the MEM stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package simplerisc_pkg;

    // Encoding of the pipeline bubble instruction.
    localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

    // Major opcodes in instruction bits [31:27].
    localparam logic [4:0] OPC_LD = 5'b01110;
    localparam logic [4:0] OPC_ST = 5'b01111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Major opcode field of an instruction word.
    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[31:27];
    endfunction

endpackage

// File: rtl/lsu_ctrl.sv
// Load/store request FSM: issues one req/ack data-memory access per ld/st, holds the request stable until ack.
// Latency: request in the issue cycle, completion no earlier than the following cycle (min 2 cycles per access).
// Backpressure: mem_stall is high from issue until the ack (or timeout abort) cycle; ack_take strobes completion.
// Optional feature macro: MEM_TIMEOUT_EN (BUSY abort after TIMEOUT_CYCLES cycles, sticky mem_err).
// Ports: clk/rst; is_ld/is_st/addr/wdata from the E-M buffer; dmem_* memory port; mem_stall, ack_take, mem_err.
module lsu_ctrl
    import simplerisc_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_ld,
    input  logic              is_st,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              mem_stall,
    output logic              ack_take,
    output logic              mem_err
);

    mem_state_t        state_q;
    mem_state_t        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              memop;
    logic              timeout_hit;
    logic              req_raw;
    logic              stall_raw;

    assign memop = is_ld | is_st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && memop) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                // ld+st together is resolved as a store.
                we_q    <= is_st;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Abort in the TIMEOUT_CYCLES-th BUSY cycle that still has no ack.
    assign timeout_hit = (state_q == BUSY) && !dmem_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            // Held at zero in IDLE so every BUSY entry starts counting from 0.
            if (state_q == IDLE) begin
                cnt_q <= '0;
            end else if (!dmem_ack) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_err = err_q;
`else
    localparam int TIMEOUT_CYCLES_UNUSED = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_raw    = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        stall_raw  = 1'b0;
        ack_take   = 1'b0;
        case (state_q)
            IDLE: begin
                // Acks seen in IDLE (including the request cycle) are ignored.
                if (memop) begin
                    req_raw    = 1'b1;
                    dmem_we    = is_st;
                    dmem_addr  = addr;
                    dmem_wdata = wdata;
                    stall_raw  = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // Driven from the latch so the port cannot move while the ack is pending.
                req_raw    = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                if (dmem_ack) begin
                    ack_take = 1'b1;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gated by reset so the request drops the instant reset asserts,
    // even with a ld/st still presented on the inputs.
    assign dmem_req  = req_raw & rst;
    assign mem_stall = stall_raw & rst;

endmodule

// File: rtl/memory_cycle.sv
// SimpleRISC MEM stage: runs ld/st through lsu_ctrl, registers the M-W buffer, sources EX forwarding values.
// Latency: 1 cycle for non-memory ops; 2+ cycles for ld/st (request cycle, then until ack).
// Backpressure: mem_stall freezes upstream while an access is outstanding; M-W buffer loads a bubble meanwhile.
// Optional feature macro: MEM_TIMEOUT_EN (timeout abort and sticky mem_err inside lsu_ctrl).
// Ports: E-M buffer inputs (*_M), dmem req/ack port, mem_stall, forwarding (data_M_E, memory_data_out), M-W buffer (*_W), mem_err.
module memory_cycle
    import simplerisc_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_M,
    input  logic [DATA_W-1:0] alu_result_M,
    input  logic [DATA_W-1:0] rd2_M,
    input  logic [31:0]       instruction_M,
    input  logic              isSt_M,
    input  logic              isLd_M,
    input  logic              isWb_M,
    input  logic              isCall_M,
    input  logic [3:0]        RD_M,
    input  logic [3:0]        ra_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_stall,
    output logic [DATA_W-1:0] data_M_E,
    output logic [DATA_W-1:0] memory_data_out,
    output logic [31:0]       pc_W,
    output logic [DATA_W-1:0] alu_result_W,
    output logic [DATA_W-1:0] ld_result_W,
    output logic [31:0]       instruction_W,
    output logic              isWb_W,
    output logic              isLd_W,
    output logic              isCall_W,
    output logic [3:0]        RD_W,
    output logic [3:0]        ra_W,
    output logic              mem_err
);

    logic ack_take;
    logic is_load;

    // A ld+st combination is a store, so it never returns load data.
    assign is_load = isLd_M & ~isSt_M;

    lsu_ctrl #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_lsu_ctrl (
        .clk        (clk),
        .rst        (rst),
        .is_ld      (isLd_M),
        .is_st      (isSt_M),
        .addr       (alu_result_M[ADDR_W-1:0]),
        .wdata      (rd2_M),
        .dmem_ack   (dmem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .mem_stall  (mem_stall),
        .ack_take   (ack_take),
        .mem_err    (mem_err)
    );

    // M-W buffer. While stalled it holds a bubble so the instruction still
    // sitting in MEM is written back exactly once, on its completion edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_W          <= '0;
            alu_result_W  <= '0;
            ld_result_W   <= '0;
            instruction_W <= NOP_INSTR;
            isWb_W        <= 1'b0;
            isLd_W        <= 1'b0;
            isCall_W      <= 1'b0;
            RD_W          <= '0;
            ra_W          <= '0;
        end else if (mem_stall) begin
            instruction_W <= NOP_INSTR;
            isWb_W        <= 1'b0;
            isLd_W        <= 1'b0;
            isCall_W      <= 1'b0;
        end else begin
            pc_W          <= pc_M;
            alu_result_W  <= alu_result_M;
            ld_result_W   <= (ack_take && is_load) ? dmem_rdata : '0;
            instruction_W <= instruction_M;
            isWb_W        <= isWb_M;
            isLd_W        <= isLd_M;
            isCall_W      <= isCall_M;
            RD_W          <= RD_M;
            ra_W          <= ra_M;
        end
    end

    assign data_M_E        = alu_result_M;
    assign memory_data_out = ld_result_W;

endmodule
